// File: rtl/cnu_min_sum_array.sv
// Six-way min-sum check node array, 2-stage elastic valid/ready pipe.
// Define CNU_OFFSET_EN for offset min-sum (OFFSET subtracted, floor 0).
module cnu_min_sum_array #(
  parameter int DATA_WIDTH = 6,
  parameter int OFFSET     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [35:0][DATA_WIDTH-1:0] data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [35:0][DATA_WIDTH-1:0] data_out
);

  localparam int MW = DATA_WIDTH - 1;

  typedef logic [MW-1:0] mag_t;

  if (DATA_WIDTH < 2 || OFFSET < 0 || OFFSET >= (1 << MW)) begin : g_bad_cfg
    $error("cnu_min_sum_array: bad DATA_WIDTH/OFFSET");
  end

`ifdef CNU_OFFSET_EN
  localparam mag_t OFF = mag_t'(OFFSET);
`endif

  // Final magnitude shaping: saturating offset or pass-through.
  function automatic mag_t shape(input mag_t m);
`ifdef CNU_OFFSET_EN
    return (m > OFF) ? m - OFF : '0;
`else
    return m;
`endif
  endfunction

  logic s1_valid;
  logic s2_valid;
  logic s2_adv;

  logic [5:0][MW-1:0] s1_min1;
  logic [5:0][MW-1:0] s1_min2;
  logic [5:0][2:0]    s1_idx;
  logic [5:0]         s1_sall;
  logic [35:0]        s1_sgn;

  logic [5:0][MW-1:0] c_min1;
  logic [5:0][MW-1:0] c_min2;
  logic [5:0][2:0]    c_idx;
  logic [5:0]         c_sall;
  logic [35:0]        c_sgn;

  logic [35:0][DATA_WIDTH-1:0] nxt;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;

  // S1 compare tree: min1/idx (lowest index on ties), min2, sign parity.
  always_comb begin
    c_min1 = '1;
    c_min2 = '1;
    c_idx  = '0;
    c_sall = '0;
    c_sgn  = '0;
    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < 6; i++) begin
        if (data_in[6*g+i][MW-1:0] < c_min1[g]) begin
          c_min2[g] = c_min1[g];
          c_min1[g] = data_in[6*g+i][MW-1:0];
          c_idx[g]  = 3'(i);
        end else if (data_in[6*g+i][MW-1:0] < c_min2[g]) begin
          c_min2[g] = data_in[6*g+i][MW-1:0];
        end
        c_sgn[6*g+i] = data_in[6*g+i][DATA_WIDTH-1];
        c_sall[g]    = c_sall[g] ^ data_in[6*g+i][DATA_WIDTH-1];
      end
    end
  end

  // S2 per-edge select: min2 on the argmin edge, min1 elsewhere.
  always_comb begin
    nxt = '0;
    for (int g = 0; g < 6; g++) begin
      for (int j = 0; j < 6; j++) begin
        nxt[6*g+j] = {
          s1_sall[g] ^ s1_sgn[6*g+j],
          shape((s1_idx[g] == 3'(j)) ? s1_min2[g] : s1_min1[g])
        };
      end
    end
  end

  // Pipeline registers; S1 refills in the same cycle S2 drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_min1  <= '0;
      s1_min2  <= '0;
      s1_idx   <= '0;
      s1_sall  <= '0;
      s1_sgn   <= '0;
      data_out <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          data_out <= nxt;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_min1 <= c_min1;
          s1_min2 <= c_min2;
          s1_idx  <= c_idx;
          s1_sall <= c_sall;
          s1_sgn  <= c_sgn;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnu_min_sum_array.sv
// Bench for cnu_min_sum_array: extrinsic-message model plus directed vectors.
// Also builds with CNU_OFFSET_EN defined.
module tb_cnu_min_sum_array;

  localparam int DW  = 6;
  localparam int MW  = 5;
  localparam int OFS = 1;

  typedef logic [35:0][DW-1:0] word_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  in_valid = 1'b0;
  logic  out_ready = 1'b0;
  word_t data_in = '0;
  logic  in_ready;
  logic  out_valid;
  word_t data_out;

  int checks = 0;
  int failures = 0;

  word_t expq[$];

  cnu_min_sum_array #(.DATA_WIDTH(DW), .OFFSET(OFS)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Extrinsic message straight from its definition: min and sign
  // parity over the other five edges of the same check node.
  function automatic word_t model(input word_t w);
    word_t r;
    int    m;
    bit    s;
    r = '0;
    for (int g = 0; g < 6; g++) begin
      for (int j = 0; j < 6; j++) begin
        m = (1 << MW) - 1;
        s = 1'b0;
        for (int k = 0; k < 6; k++) begin
          if (k != j) begin
            if (int'(w[6*g+k][MW-1:0]) < m) m = int'(w[6*g+k][MW-1:0]);
            s = s ^ w[6*g+k][DW-1];
          end
        end
`ifdef CNU_OFFSET_EN
        m = (m > OFS) ? m - OFS : 0;
`endif
        r[6*g+j] = {s, MW'(m)};
      end
    end
    return r;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < 36; i++) w[i] = DW'($urandom);
    return w;
  endfunction

  logic  stalled = 1'b0;
  word_t prev = '0;
  word_t e;

  // Scoreboard and hold-stability compare, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        if (!out_valid || data_out !== prev) begin
          failures++;
          $display("FAIL stall_hold got=%h exp=%h", data_out, prev);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out got=%h exp=none", data_out);
        end else begin
          e = expq.pop_front();
          if (data_out !== e) begin
            failures++;
            $display("FAIL out_word got=%h exp=%h", data_out, e);
          end
        end
      end
      stalled = out_valid && !out_ready;
      prev = data_out;
      if (in_valid && in_ready) expq.push_back(model(data_in));
    end
  end

  task automatic send(input word_t w);
    bit ok;
    ok = 1'b0;
    data_in = w;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  word_t w;
  int    e0[6];
  int    e2[6];
  int    acc;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out", 64'(data_out == '0), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

`ifdef CNU_OFFSET_EN
    e0 = '{2, 2, 2, 2, 2, 2};
    e2 = '{1, 33, 35, 1, 1, 33};
`else
    e0 = '{3, 3, 3, 3, 3, 3};
    e2 = '{2, 34, 36, 2, 2, 34};
`endif

    w = '0;
    w[0] = 6'd5;  w[1] = 6'd3;  w[2] = 6'd9;
    w[3] = 6'd3;  w[4] = 6'd7;  w[5] = 6'd12;
    w[12] = 6'd36; w[13] = 6'd8;  w[14] = 6'd2;
    w[15] = 6'd38; w[16] = 6'd42; w[17] = 6'd15;
    send(w);
    chk("lat_s1_only", 64'(out_valid), 64'd0);
    tick();
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("cnu0_e%0d", j), 64'(data_out[j]), 64'(e0[j]));
      chk($sformatf("cnu2_e%0d", j), 64'(data_out[12+j]), 64'(e2[j]));
    end
    tick();
    chk("single_drained", 64'(out_valid), 64'd0);

    w = '0;
    w[30] = 6'h20;
    for (int j = 31; j < 36; j++) w[j] = 6'd31;
    send(w);
    tick();
`ifndef CNU_OFFSET_EN
    chk("negz_e0", 64'(data_out[30]), 64'd31);
    for (int j = 1; j < 6; j++)
      chk($sformatf("negz_e%0d", j), 64'(data_out[30+j]), 64'd32);
`endif
    repeat (3) tick();

    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_in = rand_word();
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (i >= 2) chk("stream_out_valid", 64'(out_valid), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();

    out_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      data_in = rand_word();
      if (in_ready) acc++;
      tick();
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_drain0", 64'(out_valid), 64'd1);
    tick();
    chk("bp_drain1", 64'(out_valid), 64'd1);
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);
    repeat (2) tick();

    out_ready = 1'b0;
    send(rand_word());
    send(rand_word());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(data_out == '0), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_rst_no_stale", 64'(out_valid), 64'd0);
    end

    chk("queue_empty", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
